// File: rtl/score_pkg.sv
// Shared types and width helpers for the score tracker and its BCD converter.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  function automatic int bcd_w(input int digits);
    return 4 * digits;
  endfunction

  // Counter width that stays at least one bit wide for degenerate sizes.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd_dd_conv.sv
// Sequential double-dabble converter: one shift per cycle, result committed atomically.
module bcd_dd_conv
  import score_pkg::*;
#(
  parameter int SCORE_W = 10,
  parameter int DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  nRst,
  input  logic                  start,
  input  logic [SCORE_W-1:0]    value,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  valid,
  output logic [SCORE_W-1:0]    last_value,
  output conv_state_t           state
);

  localparam int BCD_W = bcd_w(DIGITS);
  localparam int CNT_W = cnt_w(SCORE_W);
  localparam int WRK_W = BCD_W + SCORE_W;

  conv_state_t          state_q;
  logic [WRK_W-1:0]     work_q;
  logic [SCORE_W-1:0]   val_q;
  logic [SCORE_W-1:0]   last_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [BCD_W-1:0]     bcd_q;
  logic                 valid_q;

  // One double-dabble step: correct every BCD nibble, then shift the whole word.
  function automatic logic [WRK_W-1:0] dabble(input logic [WRK_W-1:0] w);
    logic [WRK_W-1:0] t;
    t = w;
    for (int i = 0; i < DIGITS; i++) begin
      if (t[SCORE_W + 4*i +: 4] >= 4'd5)
        t[SCORE_W + 4*i +: 4] = t[SCORE_W + 4*i +: 4] + 4'd3;
    end
    return {t[WRK_W-2:0], 1'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q <= IDLE;
      work_q  <= '0;
      val_q   <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            work_q  <= {{BCD_W{1'b0}}, value};
            val_q   <= value;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          work_q <= dabble(work_q);
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(SCORE_W - 1))
            state_q <= DONE;
        end
        DONE: begin
          bcd_q   <= work_q[SCORE_W +: BCD_W];
          last_q  <= val_q;
          valid_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bcd        = bcd_q;
  assign valid      = valid_q;
  assign last_value = last_q;
  assign state      = state_q;

endmodule

// File: rtl/score_scan_display.sv
// Score/high-score tracker feeding a BCD converter, a multiplexed digit scanner and a new-high blinker.
module score_scan_display
  import score_pkg::*;
#(
  parameter int SCORE_W     = 10,
  parameter int DIGITS      = 4,
  parameter int MAX_SCORE   = 999,
  parameter int REFRESH_DIV = 4,
  parameter int BLINK_DIV   = 50
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               goodColl,
  input  logic               badColl,
  input  logic               clearHigh,
  output logic [SCORE_W-1:0] dispScore,
  output logic [SCORE_W-1:0] highScore,
  output logic               isGameComplete,
  output logic               newHigh,
  output logic               bcdValid,
  output logic [3:0]         dispDigit,
  output logic [DIGITS-1:0]  dispSel,
  output logic               dispBlank
);

  localparam int BCD_W = bcd_w(DIGITS);
  localparam int IDX_W = cnt_w(DIGITS);
  localparam int REF_W = cnt_w(REFRESH_DIV);
  localparam int BLK_W = cnt_w(BLINK_DIV);
  localparam logic [SCORE_W-1:0] MAX_S = SCORE_W'(MAX_SCORE);

  if (MAX_SCORE >= 10**DIGITS || MAX_SCORE >= 2**SCORE_W || MAX_SCORE < 1 ||
      REFRESH_DIV < 1 || BLINK_DIV < 1) begin : g_param_check
    $error("score_scan_display: illegal parameter combination");
  end

  logic [SCORE_W-1:0] curr_q, curr_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic [SCORE_W-1:0] disp_q, disp_d;
  logic               complete_q, complete_d;
  logic               new_high_q, new_high_d;
  logic [REF_W-1:0]   ref_q, ref_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BLK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;

  logic [BCD_W-1:0]   bcd;
  logic [SCORE_W-1:0] last_conv;
  logic               conv_start;
  conv_state_t        conv_state;
  logic               blink_active;
  logic               any_nz;

  // Game end (explicit or by hitting the cap) outranks a point in the same cycle.
  always_comb begin
    curr_d     = curr_q;
    complete_d = complete_q;
    new_high_d = new_high_q;
    high_d     = high_q;
    if (badColl || curr_q == MAX_S) begin
      curr_d     = '0;
      complete_d = 1'b1;
      new_high_d = (curr_q != '0) && (curr_q == high_q);
    end else if (goodColl) begin
      if (complete_q) begin
        complete_d = 1'b0;
        new_high_d = 1'b0;
        curr_d     = SCORE_W'(1);
      end else begin
        curr_d = curr_q + 1'b1;
      end
    end
    if (clearHigh) begin
      high_d     = curr_d;
      new_high_d = 1'b0;
    end else if (curr_d > high_q) begin
      high_d = curr_d;
    end
    disp_d = complete_d ? high_d : curr_d;
  end

  assign blink_active = complete_q && new_high_q;

  always_comb begin
    ref_d = ref_q + 1'b1;
    idx_d = idx_q;
    if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    blink_cnt_d = '0;
    phase_d     = 1'b0;
    if (blink_active) begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      phase_d     = phase_q;
      if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        phase_d     = !phase_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      curr_q      <= '0;
      high_q      <= '0;
      disp_q      <= '0;
      complete_q  <= 1'b0;
      new_high_q  <= 1'b0;
      ref_q       <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      curr_q      <= curr_d;
      high_q      <= high_d;
      disp_q      <= disp_d;
      complete_q  <= complete_d;
      new_high_q  <= new_high_d;
      ref_q       <= ref_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // Only request a conversion when the converter can accept it; it keeps the latest value.
  assign conv_start = (conv_state == IDLE) && (disp_q != last_conv);

  bcd_dd_conv #(
    .SCORE_W (SCORE_W),
    .DIGITS  (DIGITS)
  ) u_conv (
    .clk        (clk),
    .nRst       (nRst),
    .start      (conv_start),
    .value      (disp_q),
    .bcd        (bcd),
    .valid      (bcdValid),
    .last_value (last_conv),
    .state      (conv_state)
  );

  always_comb begin
    dispSel        = '0;
    dispSel[idx_q] = 1'b1;
    dispDigit      = bcd[4*idx_q +: 4];
    any_nz         = 1'b0;
    for (int j = 0; j < DIGITS; j++) begin
      if (IDX_W'(j) >= idx_q && bcd[4*j +: 4] != 4'd0)
        any_nz = 1'b1;
    end
    dispBlank = phase_q || ((idx_q != '0) && !any_nz);
  end

  assign dispScore      = disp_q;
  assign highScore      = high_q;
  assign isGameComplete = complete_q;
  assign newHigh        = new_high_q;

endmodule

// File: tb/tb_score_scan_display.sv
// Directed bench for score_scan_display with a small cap and short blink period.
module tb_score_scan_display;

  localparam int SCORE_W     = 10;
  localparam int DIGITS      = 4;
  localparam int MAX_SCORE   = 20;
  localparam int REFRESH_DIV = 4;
  localparam int BLINK_DIV   = 6;

  logic               clk;
  logic               n_rst;
  logic               good_coll;
  logic               bad_coll;
  logic               clear_high;
  logic [SCORE_W-1:0] disp_score;
  logic [SCORE_W-1:0] high_score;
  logic               is_complete;
  logic               new_high;
  logic               bcd_valid;
  logic [3:0]         disp_digit;
  logic [DIGITS-1:0]  disp_sel;
  logic               disp_blank;

  int n_tests = 0;
  int n_fail  = 0;
  int valid_cnt = 0;
  logic [3:0] exp_q[$];

  score_scan_display #(
    .SCORE_W     (SCORE_W),
    .DIGITS      (DIGITS),
    .MAX_SCORE   (MAX_SCORE),
    .REFRESH_DIV (REFRESH_DIV),
    .BLINK_DIV   (BLINK_DIV)
  ) dut (
    .clk            (clk),
    .nRst           (n_rst),
    .goodColl       (good_coll),
    .badColl        (bad_coll),
    .clearHigh      (clear_high),
    .dispScore      (disp_score),
    .highScore      (high_score),
    .isGameComplete (is_complete),
    .newHigh        (new_high),
    .bcdValid       (bcd_valid),
    .dispDigit      (disp_digit),
    .dispSel        (disp_sel),
    .dispBlank      (disp_blank)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bcd_valid === 1'b1) valid_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    n_rst      = 1'b0;
    good_coll  = 1'b0;
    bad_coll   = 1'b0;
    clear_high = 1'b0;
    repeat (2) @(negedge clk);
    valid_cnt  = 0;
    n_rst      = 1'b1;
  endtask

  task automatic pulse_good();
    @(negedge clk) good_coll = 1'b1;
    @(negedge clk) good_coll = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_digits(input string tag, input logic [15:0] bcd);
    bit found;
    logic [3:0] nib;
    for (int p = 0; p < DIGITS; p++) exp_q.push_back(bcd[4*p +: 4]);
    for (int p = 0; p < DIGITS; p++) begin
      found = 1'b0;
      for (int t = 0; t < DIGITS*REFRESH_DIV + 2 && !found; t++) begin
        @(negedge clk);
        if (disp_sel == DIGITS'(1 << p)) found = 1'b1;
      end
      check($sformatf("%s_sel%0d", tag, p), found, 1);
      nib = exp_q.pop_front();
      check($sformatf("%s_digit%0d", tag, p), disp_digit, nib);
      check($sformatf("%s_blank%0d", tag, p), disp_blank, (p > 0) && ((bcd >> (4*p)) == 16'h0));
    end
  endtask

  initial begin
    int k;
    int blank_hits;
    bit exp_phase;

    do_reset();
    check("rst_disp", disp_score, 0);
    check("rst_high", high_score, 0);
    check("rst_complete", is_complete, 0);
    check("rst_newhigh", new_high, 0);
    check("rst_valid", bcd_valid, 0);
    check("rst_sel", disp_sel, 1);
    check("rst_digit", disp_digit, 0);
    check("rst_blank", disp_blank, 0);

    // 12 spaced points; first one also measures conversion latency
    pulse_good();
    k = 0;
    for (int t = 1; t <= 40 && k == 0; t++) begin
      @(negedge clk);
      if (bcd_valid) k = t;
    end
    check("conv_latency", k, SCORE_W + 2);
    idle(3);
    for (int i = 1; i < 12; i++) begin
      pulse_good();
      idle(15);
    end
    check("t1_disp", disp_score, 12);
    check("t1_high", high_score, 12);
    check("t1_complete", is_complete, 0);
    check("t1_valid_cnt", valid_cnt, 12);
    check_digits("t1", 16'h0012);

    // goodColl and badColl together at 5
    do_reset();
    for (int i = 0; i < 5; i++) pulse_good();
    @(negedge clk) begin good_coll = 1'b1; bad_coll = 1'b1; end
    @(negedge clk) begin good_coll = 1'b0; bad_coll = 1'b0; end
    check("t2_disp", disp_score, 5);
    check("t2_high", high_score, 5);
    check("t2_complete", is_complete, 1);
    check("t2_newhigh", new_high, 1);

    // new game below the high score: no new high, no blinking
    pulse_good();
    check("t3_restart_complete", is_complete, 0);
    check("t3_restart_newhigh", new_high, 0);
    check("t3_restart_disp", disp_score, 1);
    idle(15);
    pulse_good();
    idle(15);
    pulse_good();
    idle(15);
    @(negedge clk) bad_coll = 1'b1;
    @(negedge clk) bad_coll = 1'b0;
    check("t3_high", high_score, 5);
    check("t3_newhigh", new_high, 0);
    check("t3_complete", is_complete, 1);
    check("t3_disp", disp_score, 5);
    idle(15);
    blank_hits = 0;
    for (int t = 0; t < 4*BLINK_DIV; t++) begin
      @(negedge clk);
      if (disp_sel == 4'b0001 && disp_blank) blank_hits++;
    end
    check("t3_no_blink", blank_hits, 0);
    check_digits("t3", 16'h0005);

    @(negedge clk) clear_high = 1'b1;
    @(negedge clk) clear_high = 1'b0;
    check("clr_high", high_score, 0);
    check("clr_disp", disp_score, 0);

    // run to the cap: game completes on its own and blinks
    do_reset();
    for (int i = 0; i < MAX_SCORE; i++) begin
      pulse_good();
      idle(1);
    end
    // last pulse landed two posedges ago; re-align to count posedges since it
    check("t4_at_cap_complete", is_complete, 1);
    check("t4_at_cap_high", high_score, MAX_SCORE);
    check("t4_at_cap_newhigh", new_high, 1);
    check("t4_at_cap_disp", disp_score, MAX_SCORE);
    for (int kk = 2; kk <= 2*BLINK_DIV + 3; kk++) begin
      @(negedge clk);
      exp_phase = (kk >= BLINK_DIV + 1) && (kk <= 2*BLINK_DIV);
      check($sformatf("t4_blink_k%0d", kk), disp_blank,
            exp_phase || disp_sel[2] || disp_sel[3]);
    end

    // burst of three points: final BCD must settle on 3
    do_reset();
    @(negedge clk) good_coll = 1'b1;
    repeat (3) @(negedge clk);
    good_coll = 1'b0;
    idle(40);
    check("t5_disp", disp_score, 3);
    check("t5_valid_cnt", valid_cnt, 2);
    check_digits("t5", 16'h0003);

    // reset in the middle of a conversion
    do_reset();
    pulse_good();
    idle(4);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    valid_cnt = 0;
    check("t6_disp", disp_score, 0);
    check("t6_sel", disp_sel, 1);
    check("t6_digit", disp_digit, 0);
    check("t6_blank", disp_blank, 0);
    check("t6_valid", bcd_valid, 0);
    idle(25);
    check("t6_no_valid", valid_cnt, 0);
    pulse_good();
    idle(14);
    check("t6_restart_valid", valid_cnt, 1);
    check_digits("t6", 16'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
